// File: rtl/f_prefetch_top.sv
// rtl/f_prefetch_top.sv - fetch stage with decoupling instruction queue and F/D register
//
// Fetches one instruction per non-stalled icache cycle into a DEPTH-entry FIFO.
// The F/D register drains the FIFO whenever the back end advances. A branch
// redirect flushes the FIFO and the F/D register and steers the PC.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   stall         hazard stall from decode
//   dcache_stall  data-cache miss stall
//   br_en         redirect request (held by execute until accepted)
//   br_addr       redirect target
//   ic_addr       fetch address (PC register)
//   ic_data       instruction at ic_addr, valid when ic_stall==0
//   ic_stall      icache miss
//   icache_stall  pass-through of ic_stall
//   fd_valid      F/D holds a real instruction
//   fd_pc         F/D program counter
//   fd_instr      F/D instruction
//   fq_count      queue occupancy
module f_prefetch_top #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       dcache_stall,
  input  logic                       br_en,
  input  logic [XLEN-1:0]            br_addr,
  output logic [XLEN-1:0]            ic_addr,
  input  logic [XLEN-1:0]            ic_data,
  input  logic                       ic_stall,
  output logic                       icache_stall,
  output logic                       fd_valid,
  output logic [XLEN-1:0]            fd_pc,
  output logic [XLEN-1:0]            fd_instr,
  output logic [$clog2(DEPTH):0]     fq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] q_instr [DEPTH];

  logic adv;
  logic br_take;
  logic pop;
  logic push;

  // icache_stall deliberately does not gate adv: an empty queue yields a bubble.
  assign adv     = !stall && !dcache_stall;
  assign br_take = br_en && adv;
  assign pop     = adv && !br_en && (count != '0);
  // A full queue may still accept a push when the head leaves this cycle.
  assign push    = !br_take && !ic_stall && ((count < FULL) || pop);

  assign ic_addr      = pc_q;
  assign icache_stall = ic_stall;
  assign fq_count     = count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fd_valid <= 1'b0;
      fd_pc    <= '0;
      fd_instr <= '0;
    end else if (br_take) begin
      pc_q     <= br_addr;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fd_valid <= 1'b0;
      fd_pc    <= '0;
      fd_instr <= '0;
    end else begin
      if (push) begin
        pc_q   <= pc_q + XLEN'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (adv) begin
        if (pop) begin
          fd_valid <= 1'b1;
          fd_pc    <= q_pc[rd_ptr];
          fd_instr <= q_instr[rd_ptr];
        end else begin
          fd_valid <= 1'b0;
          fd_pc    <= '0;
          fd_instr <= '0;
        end
      end
    end
  end

  // Storage needs no reset: entries are only read when count says they are live.
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr]    <= pc_q;
      q_instr[wr_ptr] <= ic_data;
    end
  end

endmodule

// File: tb/tb_f_prefetch_top.sv
// tb/tb_f_prefetch_top.sv - self-checking bench for f_prefetch_top
module tb_f_prefetch_top;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        dcache_stall;
  logic        br_en;
  logic [31:0] br_addr;
  logic [31:0] ic_addr;
  logic [31:0] ic_data;
  logic        ic_stall;
  logic        icache_stall;
  logic        fd_valid;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic [2:0]  fq_count;

  int checks = 0;
  int errors = 0;

  f_prefetch_top #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .dcache_stall(dcache_stall),
    .br_en(br_en),
    .br_addr(br_addr),
    .ic_addr(ic_addr),
    .ic_data(ic_data),
    .ic_stall(ic_stall),
    .icache_stall(icache_stall),
    .fd_valid(fd_valid),
    .fd_pc(fd_pc),
    .fd_instr(fd_instr),
    .fq_count(fq_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Icache model: instruction = address + 0x13; garbage while missing.
  assign ic_data = ic_stall ? 32'hDEADBEEF : ic_addr + 32'h13;

  typedef struct {
    logic        st;
    logic        ds;
    logic        br;
    logic [31:0] ba;
    logic        ics;
    logic        ev;
    logic [31:0] epc;
    logic [2:0]  ecnt;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic ds, input logic br, input logic [31:0] ba,
                     input logic ics, input logic ev, input logic [31:0] epc,
                     input logic [2:0] ecnt, input logic [31:0] eaddr);
    vec_t v;
    v.st = st; v.ds = ds; v.br = br; v.ba = ba; v.ics = ics;
    v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eaddr = eaddr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [2:0] ecnt, input logic [31:0] eaddr);
    chk({tag, ".fd_valid"}, {31'b0, fd_valid}, {31'b0, ev});
    chk({tag, ".fd_pc"}, fd_pc, epc);
    chk({tag, ".fd_instr"}, fd_instr, ev ? epc + 32'h13 : 32'h0);
    chk({tag, ".fq_count"}, {29'b0, fq_count}, {29'b0, ecnt});
    chk({tag, ".ic_addr"}, ic_addr, eaddr);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; dcache_stall = 1'b0;
    br_en = 1'b0; br_addr = '0; ic_stall = 1'b0;

    // st ds br ba           ics  ev epc          cnt addr
    add(0, 0, 0, 0,            0,  0, 0,            1, 32'h4);   // first push
    add(0, 0, 0, 0,            0,  1, 0,            1, 32'h8);   // 2-edge latency
    add(0, 0, 0, 0,            0,  1, 32'h4,        1, 32'hc);
    add(0, 0, 0, 0,            0,  1, 32'h8,        1, 32'h10);
    add(1, 0, 0, 0,            0,  1, 32'h8,        2, 32'h14);  // stall: fill queue
    add(1, 0, 0, 0,            0,  1, 32'h8,        3, 32'h18);
    add(1, 0, 0, 0,            0,  1, 32'h8,        4, 32'h1c);
    add(1, 0, 0, 0,            0,  1, 32'h8,        4, 32'h1c);  // full: PC frozen
    add(1, 0, 0, 0,            0,  1, 32'h8,        4, 32'h1c);
    add(1, 0, 0, 0,            0,  1, 32'h8,        4, 32'h1c);
    add(0, 0, 0, 0,            0,  1, 32'hc,        4, 32'h20);  // push+pop while full
    add(0, 0, 0, 0,            0,  1, 32'h10,       4, 32'h24);
    add(0, 0, 0, 0,            0,  1, 32'h14,       4, 32'h28);
    add(0, 0, 0, 0,            0,  1, 32'h18,       4, 32'h2c);
    add(0, 0, 0, 0,            1,  1, 32'h1c,       3, 32'h2c);  // icache miss: drain
    add(0, 0, 0, 0,            1,  1, 32'h20,       2, 32'h2c);
    add(0, 0, 0, 0,            1,  1, 32'h24,       1, 32'h2c);
    add(0, 0, 0, 0,            1,  1, 32'h28,       0, 32'h2c);
    add(0, 0, 0, 0,            1,  0, 0,            0, 32'h2c);  // empty: bubble
    add(0, 0, 0, 0,            0,  0, 0,            1, 32'h30);  // miss clears
    add(0, 0, 0, 0,            0,  1, 32'h2c,       1, 32'h34);
    add(1, 0, 0, 0,            0,  1, 32'h2c,       2, 32'h38);
    add(1, 0, 0, 0,            0,  1, 32'h2c,       3, 32'h3c);
    add(1, 0, 0, 0,            0,  1, 32'h2c,       4, 32'h40);
    add(0, 1, 1, 32'h100,      0,  1, 32'h2c,       4, 32'h40);  // br ignored in dcache stall
    add(0, 1, 1, 32'h100,      0,  1, 32'h2c,       4, 32'h40);
    add(0, 0, 1, 32'h100,      0,  0, 0,            0, 32'h100); // redirect from full
    add(0, 0, 0, 0,            0,  0, 0,            1, 32'h104);
    add(0, 0, 0, 0,            0,  1, 32'h100,      1, 32'h108);
    add(0, 0, 0, 0,            0,  1, 32'h104,      1, 32'h10c);
    add(0, 0, 1, 32'hfffffffc, 0,  0, 0,            0, 32'hfffffffc);
    add(0, 0, 0, 0,            0,  0, 0,            1, 32'h0);   // PC wraps
    add(0, 0, 0, 0,            0,  1, 32'hfffffffc, 1, 32'h4);

    #12;
    chk_state("reset", 1'b0, 32'h0, 3'd0, 32'h0);
    chk("reset.icache_stall", {31'b0, icache_stall}, 32'h0);

    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clock);
      stall = vecs[i].st; dcache_stall = vecs[i].ds;
      br_en = vecs[i].br; br_addr = vecs[i].ba; ic_stall = vecs[i].ics;
      #1;
      chk($sformatf("v%0d.icache_stall", i), {31'b0, icache_stall}, {31'b0, vecs[i].ics});
      @(posedge clock);
      #1;
      chk_state($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ecnt, vecs[i].eaddr);
    end

    // Asynchronous reset mid-stream, between edges.
    @(negedge clock);
    stall = 1'b0; dcache_stall = 1'b0; br_en = 1'b0; ic_stall = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, 32'h0, 3'd0, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_state("restart0", 1'b0, 32'h0, 3'd1, 32'h4);
    @(posedge clock);
    #1;
    chk_state("restart1", 1'b1, 32'h0, 3'd1, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
